commit_unit: RTL and testbench
==============================

Name: commit_unit

Overview:
- Retire stage of the single-cycle teaching CPU. Consumes the ALU's decoded outputs and performs the architectural side effects:
  - register-file write-back
  - data-RAM load/store
  - in/out device transfers
  - PC update
- It is the consumer end of the ALU result interface. The ALU drives it; it owns the register file, the data RAM and the PC.
- The fetch/decode side reads operands through its combinational read ports.

Parameters:
- PC_LIMIT, 30, program length; PC reaching this value halts the unit.
- INSTR_LIMIT, 30, maximum committed instructions before halt.
- DEPTH, 32, entries in register file and in data RAM (address width 5).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU outputs valid for current instruction.
- alu_ready  out  1  high in IDLE only; a transfer happens when alu_valid && alu_ready.
- wb_addr  in  5  write-back register, or branch/jump target.
- result  in  32  ALU result.
- is_branch  in  1  taken branch/jump.
- is_jal  in  1  jump-and-link.
- load_write  in  2  10=lw, 01=sw, other=none.
- lw_addr  in  5  data-RAM address for lw/sw.
- in_out  in  2  10=in, 01=out, other=none.
- io_addr  in  5  data-RAM address for in/out.
- rs_addr, rt_addr, rd_addr  in  5 each  operand read addresses.
- rs_data, rt_data, rd_data  out  32 each  combinational register reads.
- in_data  in  32  input-device word.
- in_valid  in  1  input word available.
- in_ready  out  1  unit waiting for input word.
- out_data  out  32  word for display device.
- out_valid  out  1  out_data valid.
- out_ready  in  1  display accepted word.
- pc  out  5  current PC.
- commit  out  1  one-cycle pulse per retired instruction.
- instr_count  out  6  retired instructions.
- halted  out  1  sticky halt flag.

Behaviour:
- Reset values:
  - pc=0, instr_count=0, halted=0, commit=0, out_valid=0, in_ready=0.
  - Every register is 0; data RAM entry i = i.
  - State is IDLE.
  - Reset during any state aborts the operation; a pending in/out handshake is dropped.
- States: IDLE, LOAD, IN_WAIT, OUT_WAIT, HALT.
- IDLE:
  - If pc>=PC_LIMIT or instr_count>=INSTR_LIMIT: go to HALT. On entering HALT, the register file and data RAM are re-initialised to reset contents.
  - Otherwise, on an accepted transfer, decode with fixed precedence lw > sw > in > out > other:
    - lw: latch lw_addr/wb_addr, go to LOAD.
    - sw: data[lw_addr] <= reg[wb_addr]; pc+1; commit; stay IDLE.
    - in: go to IN_WAIT with in_ready=1.
    - out: out_data <= data[io_addr]; out_valid=1; go to OUT_WAIT.
    - other, is_branch=1: pc <= wb_addr, no register write.
    - other, is_branch=0: reg[wb_addr] <= result; pc+1.
    - is_jal=1 (other class): reg[31] <= pc+1 (link). Link write wins over result write when wb_addr=31.
- LOAD: registered RAM read; reg[latched wb_addr] <= data[latched lw_addr]; pc+1; commit; return to IDLE. lw latency is 2 cycles; every other ALU-only op is 1 cycle.
- IN_WAIT: on in_valid, data[io_addr] <= in_data; in_ready drops; pc+1; commit; IDLE.
- OUT_WAIT: out_valid held with out_data stable until out_ready; then out_valid=0, pc+1, commit, IDLE.
- HALT: absorbing until reset; alu_ready=0, halted=1.
- commit increments instr_count (saturates at 63) in the same cycle.
- PC arithmetic is 5-bit wrap (31+1=0). Wrap is irrelevant while PC_LIMIT<32.
- Read ports are combinational. A write and a read of the same address in the same cycle return the old value; there is no bypass.

Optional Feature:
- ZERO_REG_EN defined: register 0 is hardwired to 0. Writes to address 0, including lw and link targets, are discarded, and rs/rt/rd reads of address 0 return 0.
- ZERO_REG_EN undefined: register 0 is an ordinary writable register.

Test Plan:
- Reset, then read all ports -> every register 0, data[5]=5, pc=0, alu_ready=1, halted=0.
- Normal op wb_addr=16, result=3 -> one cycle later reg16=3, pc=1, commit pulse, instr_count=1.
- lw with lw_addr=16, wb_addr=1 -> alu_ready low for 1 cycle, then reg1=16, pc+1. Follow with sw wb_addr=1, lw_addr=2 -> data[2]=16.
- in with io_addr=31, in_valid delayed 4 cycles with in_data=0xDEAD -> in_ready high 4 cycles, then data[31]=0xDEAD. Follow with out io_addr=31, out_ready delayed 3 cycles -> out_data=0xDEAD stable, out_valid held until accepted.
- jal with is_branch=1, is_jal=1, wb_addr=24 at pc=23 -> pc=24, reg31=24. Branch-only with wb_addr=21 -> pc=21, no register change.
- 30 normal ops back-to-back -> halted=1 after the 30th commit, alu_ready=0, data[3]=3, registers 0. Assert reset mid-IN_WAIT -> IDLE, in_ready=0, pc=0.

Source files
------------

// File: rtl/commit_unit.sv
// commit_unit: retire stage of the single-cycle teaching CPU.
//
// Takes the ALU's decoded outputs and performs the architectural side
// effects of each instruction: register write-back, data-RAM load/store,
// in/out device transfers and the PC update. The unit owns the register
// file, the data RAM and the PC. Fetch/decode reads operands through the
// combinational rs/rt/rd read ports.
//
// Optional feature macro: ZERO_REG_EN
//   defined   -> register 0 is hardwired to zero (writes dropped, reads 0)
//   undefined -> register 0 is an ordinary register
//
// Ports:
//   clk, reset                      clock (rising edge), synchronous active-high reset
//   alu_valid / alu_ready           ALU handshake; ready only while IDLE and not at a limit
//   wb_addr, result                 write-back register (or branch target) and ALU result
//   is_branch, is_jal               taken branch/jump, jump-and-link
//   load_write, lw_addr             10=lw, 01=sw; data-RAM address
//   in_out, io_addr                 10=in, 01=out; data-RAM address
//   rs/rt/rd_addr -> rs/rt/rd_data  combinational register reads (no bypass)
//   in_data, in_valid, in_ready     input device handshake
//   out_data, out_valid, out_ready  display device handshake
//   pc, commit, instr_count, halted architectural status
module commit_unit #(
  parameter int PC_LIMIT    = 30,
  parameter int INSTR_LIMIT = 30,
  parameter int DEPTH       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] result,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic [1:0]  load_write,
  input  logic [4:0]  lw_addr,
  input  logic [1:0]  in_out,
  input  logic [4:0]  io_addr,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] rd_data,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  pc,
  output logic        commit,
  output logic [5:0]  instr_count,
  output logic        halted
);

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [5:0] PC_LIM    = 6'(PC_LIMIT);
  localparam logic [5:0] INSTR_LIM = 6'(INSTR_LIMIT);

  typedef enum logic [2:0] {IDLE, LOAD, IN_WAIT, OUT_WAIT, HALT} state_t;

  state_t      state;
  state_t      next_state;

  logic [31:0] regs     [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic [4:0]  ld_addr_q;
  logic [4:0]  ld_wb_q;
  logic [4:0]  io_addr_q;

  logic        is_lw;
  logic        is_sw;
  logic        is_in;
  logic        is_out;
  logic        limit_hit;
  logic        do_commit;
  logic        reinit;

  function automatic logic writable(input logic [4:0] addr);
    return !(ZERO_REG && (addr == 5'd0));
  endfunction

  assign is_lw  = (load_write == 2'b10);
  assign is_sw  = (load_write == 2'b01);
  assign is_in  = (in_out == 2'b10);
  assign is_out = (in_out == 2'b01);

  assign limit_hit = ({1'b0, pc} >= PC_LIM) || (instr_count >= INSTR_LIM);

  assign rs_data = (ZERO_REG && (rs_addr == 5'd0)) ? 32'd0 : regs[rs_addr];
  assign rt_data = (ZERO_REG && (rt_addr == 5'd0)) ? 32'd0 : regs[rt_addr];
  assign rd_data = (ZERO_REG && (rd_addr == 5'd0)) ? 32'd0 : regs[rd_addr];

  assign in_ready  = (state == IN_WAIT);
  assign out_valid = (state == OUT_WAIT);
  assign halted    = (state == HALT);

  // Next-state and handshake decode. alu_ready is withheld once a limit is
  // reached so the ALU never hands over an instruction that would be lost
  // on the way into HALT.
  always_comb begin
    next_state = state;
    alu_ready  = 1'b0;
    do_commit  = 1'b0;
    reinit     = 1'b0;
    case (state)
      IDLE: begin
        if (limit_hit) begin
          next_state = HALT;
          reinit     = 1'b1;
        end else begin
          alu_ready = 1'b1;
          if (alu_valid) begin
            if (is_lw)       next_state = LOAD;
            else if (is_sw)  do_commit  = 1'b1;
            else if (is_in)  next_state = IN_WAIT;
            else if (is_out) next_state = OUT_WAIT;
            else             do_commit  = 1'b1;
          end
        end
      end
      LOAD: begin
        do_commit  = 1'b1;
        next_state = IDLE;
      end
      IN_WAIT: begin
        if (in_valid) begin
          do_commit  = 1'b1;
          next_state = IDLE;
        end
      end
      OUT_WAIT: begin
        if (out_ready) begin
          do_commit  = 1'b1;
          next_state = IDLE;
        end
      end
      HALT: next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  // State register and all architectural updates. Within the jal branch the
  // link write is issued after the result write so it wins when wb_addr=31.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr_count <= '0;
      commit      <= 1'b0;
      out_data    <= '0;
      ld_addr_q   <= '0;
      ld_wb_q     <= '0;
      io_addr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i]     <= '0;
        data_mem[i] <= 32'(i);
      end
    end else begin
      state  <= next_state;
      commit <= do_commit;
      if (do_commit && (instr_count != 6'h3f)) begin
        instr_count <= instr_count + 6'd1;
      end
      if (reinit) begin
        for (int i = 0; i < DEPTH; i++) begin
          regs[i]     <= '0;
          data_mem[i] <= 32'(i);
        end
      end
      case (state)
        IDLE: begin
          if (alu_ready && alu_valid) begin
            if (is_lw) begin
              ld_addr_q <= lw_addr;
              ld_wb_q   <= wb_addr;
            end else if (is_sw) begin
              data_mem[lw_addr] <= regs[wb_addr];
              pc                <= pc + 5'd1;
            end else if (is_in) begin
              io_addr_q <= io_addr;
            end else if (is_out) begin
              out_data <= data_mem[io_addr];
            end else begin
              if (is_branch) begin
                pc <= wb_addr;
              end else begin
                if (writable(wb_addr)) regs[wb_addr] <= result;
                pc <= pc + 5'd1;
              end
              if (is_jal) regs[5'd31] <= {27'd0, pc + 5'd1};
            end
          end
        end
        LOAD: begin
          if (writable(ld_wb_q)) regs[ld_wb_q] <= data_mem[ld_addr_q];
          pc <= pc + 5'd1;
        end
        IN_WAIT: begin
          if (in_valid) begin
            data_mem[io_addr_q] <= in_data;
            pc                  <= pc + 5'd1;
          end
        end
        OUT_WAIT: begin
          if (out_ready) pc <= pc + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: self-checking bench for commit_unit.
// Directed vector table, hand-written multi-cycle sequences and randomized
// transactions compared against an architectural model of the retire stage.
module tb_commit_unit;

`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  wb_addr;
  logic [31:0] result;
  logic        is_branch;
  logic        is_jal;
  logic [1:0]  load_write;
  logic [4:0]  lw_addr;
  logic [1:0]  in_out;
  logic [4:0]  io_addr;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rs_data, rt_data, rd_data;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  pc;
  logic        commit;
  logic [5:0]  instr_count;
  logic        halted;

  always #50 clk = ~clk;

  commit_unit dut (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .wb_addr(wb_addr), .result(result), .is_branch(is_branch), .is_jal(is_jal),
    .load_write(load_write), .lw_addr(lw_addr), .in_out(in_out), .io_addr(io_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .rd_data(rd_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .pc(pc), .commit(commit), .instr_count(instr_count), .halted(halted)
  );

  int checks = 0;
  int errors = 0;

  // Architectural model: register file, data RAM, PC, retired count.
  logic [31:0] m_regs [32];
  logic [31:0] m_data [32];
  logic [4:0]  m_pc;
  int          m_count;
  bit          m_halt;

  typedef struct {
    logic [4:0]  wb;
    logic [31:0] res;
    logic        br;
    logic        jal;
    logic [1:0]  lwr;
    logic [1:0]  io;
    logic [4:0]  la;
    logic [4:0]  ia;
    logic [31:0] ind;
    int          dly;
    logic [4:0]  exp_pc;
    logic [4:0]  chk_reg;
    logic [31:0] exp_reg;
    logic        chk_out;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    return (ZR && a == 5'd0) ? 32'd0 : m_regs[a];
  endfunction

  function automatic void m_write(input logic [4:0] a, input logic [31:0] v);
    if (!(ZR && a == 5'd0)) m_regs[a] = v;
  endfunction

  function automatic void modelArrays();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_data[i] = 32'(i);
    end
  endfunction

  task automatic doReset();
    alu_valid = 0; wb_addr = 0; result = 0; is_branch = 0; is_jal = 0;
    load_write = 0; lw_addr = 0; in_out = 0; io_addr = 0;
    rs_addr = 0; rt_addr = 0; rd_addr = 0;
    in_data = 0; in_valid = 0; out_ready = 0;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    modelArrays();
    m_pc = 5'd0; m_count = 0; m_halt = 0;
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'((i + 1) % 32);
      rd_addr = 5'((i + 2) % 32);
      #1;
      checkOutput({tag, "_rs"}, rs_data, m_read(5'(i)));
      checkOutput({tag, "_rt"}, rt_data, m_read(5'((i + 1) % 32)));
      checkOutput({tag, "_rd"}, rd_data, m_read(5'((i + 2) % 32)));
    end
  endtask

  // One complete instruction: ALU handshake, any device/load wait, then
  // commit-cycle checks and model update.
  task automatic applyStimulus(input logic [4:0] wb, input logic [31:0] res, input logic br,
                               input logic jal, input logic [1:0] lwr, input logic [1:0] io,
                               input logic [4:0] la, input logic [4:0] ia,
                               input logic [31:0] ind, input int dly);
    int waited = 0;
    int cls;
    logic [31:0] exp_out;
    logic [4:0] old_pc;
    if (m_halt) return;
    while (!alu_ready && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!alu_ready) begin
      checkOutput("alu_ready_timeout", 32'(alu_ready), 32'd1);
      return;
    end
    if (lwr == 2'b10)      cls = 1;
    else if (lwr == 2'b01) cls = 2;
    else if (io == 2'b10)  cls = 3;
    else if (io == 2'b01)  cls = 4;
    else                   cls = 0;
    wb_addr = wb; result = res; is_branch = br; is_jal = jal;
    load_write = lwr; in_out = io; lw_addr = la; io_addr = ia;
    alu_valid = 1;
    rs_addr = wb;
    #1;
    checkOutput("read_old_value", rs_data, m_read(wb));
    exp_out = m_data[ia];
    @(posedge clk); #1;
    alu_valid = 0;
    case (cls)
      1: begin
        checkOutput("lw_busy_ready", 32'(alu_ready), 32'd0);
        checkOutput("lw_busy_commit", 32'(commit), 32'd0);
        @(posedge clk); #1;
      end
      3: begin
        for (int i = 0; i < dly; i++) begin
          checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
          @(posedge clk); #1;
        end
        checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1; in_data = ind;
        @(posedge clk); #1;
        in_valid = 0;
        checkOutput("in_ready_drop", 32'(in_ready), 32'd0);
      end
      4: begin
        for (int i = 0; i < dly; i++) begin
          checkOutput("out_valid_hold", 32'(out_valid), 32'd1);
          checkOutput("out_data_hold", out_data, exp_out);
          @(posedge clk); #1;
        end
        checkOutput("out_valid_hold", 32'(out_valid), 32'd1);
        checkOutput("out_data_hold", out_data, exp_out);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        checkOutput("out_valid_drop", 32'(out_valid), 32'd0);
      end
      default: ;
    endcase
    old_pc = m_pc;
    case (cls)
      1: begin m_write(wb, m_data[la]); m_pc = m_pc + 5'd1; end
      2: begin m_data[la] = m_read(wb); m_pc = m_pc + 5'd1; end
      3: begin m_data[ia] = ind; m_pc = m_pc + 5'd1; end
      4: m_pc = m_pc + 5'd1;
      default: begin
        if (br) m_pc = wb;
        else begin
          m_write(wb, res);
          m_pc = m_pc + 5'd1;
        end
        if (jal) m_write(5'd31, {27'd0, 5'(old_pc + 5'd1)});
      end
    endcase
    if (m_count < 63) m_count++;
    checkOutput("commit_pulse", 32'(commit), 32'd1);
    checkOutput("pc", 32'(pc), 32'(m_pc));
    checkOutput("instr_count", 32'(instr_count), 32'(m_count));
    if (m_pc >= 5'd30 || m_count >= 30) begin
      m_halt = 1;
      modelArrays();
      @(posedge clk); #1;
      checkOutput("halt_entered", 32'(halted), 32'd1);
      checkOutput("halt_ready", 32'(alu_ready), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at time %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    logic [4:0] r_wb, r_la, r_ia;
    logic [31:0] r_res, r_ind;
    logic r_br, r_jal;
    logic [1:0] r_lwr, r_io;

    // Directed sequence from reset (data[i]=i initially).
    vecs.push_back('{5'd16, 32'd3,     1'b0, 1'b0, 2'b00, 2'b00, 5'd0,  5'd0,  32'd0,      0, 5'd1,  5'd16, 32'd3,     1'b0, 32'd0});
    vecs.push_back('{5'd1,  32'd0,     1'b0, 1'b0, 2'b10, 2'b00, 5'd16, 5'd0,  32'd0,      0, 5'd2,  5'd1,  32'd16,    1'b0, 32'd0});
    vecs.push_back('{5'd1,  32'd0,     1'b0, 1'b0, 2'b01, 2'b00, 5'd2,  5'd0,  32'd0,      0, 5'd3,  5'd1,  32'd16,    1'b0, 32'd0});
    vecs.push_back('{5'd0,  32'd0,     1'b0, 1'b0, 2'b00, 2'b10, 5'd0,  5'd31, 32'hDEAD,   4, 5'd4,  5'd16, 32'd3,     1'b0, 32'd0});
    vecs.push_back('{5'd0,  32'd0,     1'b0, 1'b0, 2'b00, 2'b01, 5'd0,  5'd31, 32'd0,      3, 5'd5,  5'd1,  32'd16,    1'b1, 32'hDEAD});
    vecs.push_back('{5'd0,  32'd0,     1'b0, 1'b0, 2'b00, 2'b01, 5'd0,  5'd2,  32'd0,      0, 5'd6,  5'd2,  32'd0,     1'b1, 32'd16});
    vecs.push_back('{5'd23, 32'h77,    1'b1, 1'b0, 2'b00, 2'b00, 5'd0,  5'd0,  32'd0,      0, 5'd23, 5'd23, 32'd0,     1'b0, 32'd0});
    vecs.push_back('{5'd24, 32'd0,     1'b1, 1'b1, 2'b00, 2'b00, 5'd0,  5'd0,  32'd0,      0, 5'd24, 5'd31, 32'd24,    1'b0, 32'd0});
    vecs.push_back('{5'd31, 32'h55,    1'b0, 1'b1, 2'b00, 2'b00, 5'd0,  5'd0,  32'd0,      0, 5'd25, 5'd31, 32'd25,    1'b0, 32'd0});
    vecs.push_back('{5'd5,  32'd0,     1'b0, 1'b0, 2'b10, 2'b10, 5'd7,  5'd9,  32'hBAD,    2, 5'd26, 5'd5,  32'd7,     1'b0, 32'd0});
    vecs.push_back('{5'd0,  32'd0,     1'b0, 1'b0, 2'b11, 2'b01, 5'd0,  5'd9,  32'd0,      1, 5'd27, 5'd5,  32'd7,     1'b1, 32'd9});
    vecs.push_back('{5'd0,  32'h99,    1'b0, 1'b0, 2'b00, 2'b00, 5'd0,  5'd0,  32'd0,      0, 5'd28, 5'd0,  ZR ? 32'd0 : 32'h99, 1'b0, 32'd0});
    vecs.push_back('{5'd21, 32'h44,    1'b1, 1'b0, 2'b00, 2'b00, 5'd0,  5'd0,  32'd0,      0, 5'd21, 5'd21, 32'd0,     1'b0, 32'd0});
    vecs.push_back('{5'd29, 32'd0,     1'b1, 1'b0, 2'b00, 2'b00, 5'd0,  5'd0,  32'd0,      0, 5'd29, 5'd29, 32'd0,     1'b0, 32'd0});
    vecs.push_back('{5'd2,  32'd7,     1'b0, 1'b0, 2'b00, 2'b00, 5'd0,  5'd0,  32'd0,      0, 5'd30, 5'd16, 32'd0,     1'b0, 32'd0});

    $display("[TB] reset checks");
    doReset();
    checkOutput("reset_pc", 32'(pc), 32'd0);
    checkOutput("reset_count", 32'(instr_count), 32'd0);
    checkOutput("reset_ready", 32'(alu_ready), 32'd1);
    checkOutput("reset_halted", 32'(halted), 32'd0);
    checkOutput("reset_commit", 32'(commit), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkRegs("reset_regs");

    $display("[TB] directed vector table");
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      applyStimulus(v.wb, v.res, v.br, v.jal, v.lwr, v.io, v.la, v.ia, v.ind, v.dly);
      checkOutput($sformatf("vec%0d_pc", k), 32'(pc), 32'(v.exp_pc));
      rs_addr = v.chk_reg;
      #1;
      checkOutput($sformatf("vec%0d_reg", k), rs_data, v.exp_reg);
      if (v.chk_out) checkOutput($sformatf("vec%0d_out", k), out_data, v.exp_out);
    end
    // Halt by PC limit is absorbing even with a valid ALU request.
    alu_valid = 1; wb_addr = 5'd3; result = 32'h1234;
    repeat (3) @(posedge clk);
    #1;
    alu_valid = 0;
    checkOutput("halt_sticky", 32'(halted), 32'd1);
    checkOutput("halt_pc_frozen", 32'(pc), 32'd30);
    checkOutput("halt_count_frozen", 32'(instr_count), 32'd15);
    checkRegs("halt_regs_cleared");

    $display("[TB] back-to-back ops to instruction limit");
    doReset();
    alu_valid = 1;
    for (int i = 0; i < 30; i++) begin
      wb_addr = 5'(i + 1);
      result = 32'(i + 100);
      @(posedge clk); #1;
      checkOutput("b2b_commit", 32'(commit), 32'd1);
      checkOutput("b2b_count", 32'(instr_count), 32'(i + 1));
    end
    checkOutput("b2b_ready_at_limit", 32'(alu_ready), 32'd0);
    @(posedge clk); #1;
    alu_valid = 0;
    checkOutput("b2b_halted", 32'(halted), 32'd1);
    checkOutput("b2b_commit_low", 32'(commit), 32'd0);
    checkOutput("b2b_count_final", 32'(instr_count), 32'd30);
    modelArrays();
    checkRegs("b2b_regs_cleared");

    $display("[TB] reset during IN_WAIT");
    doReset();
    alu_valid = 1; in_out = 2'b10; io_addr = 5'd4;
    @(posedge clk); #1;
    alu_valid = 0; in_out = 2'b00;
    checkOutput("abort_in_ready_pre", 32'(in_ready), 32'd1);
    in_valid = 1; in_data = 32'hBEEF;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; in_valid = 0;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
    checkOutput("abort_pc", 32'(pc), 32'd0);
    checkOutput("abort_ready", 32'(alu_ready), 32'd1);
    checkOutput("abort_count", 32'(instr_count), 32'd0);
    modelArrays();
    m_pc = 5'd0; m_count = 0; m_halt = 0;
    applyStimulus(5'd0, 32'd0, 1'b0, 1'b0, 2'b00, 2'b01, 5'd0, 5'd4, 32'd0, 1);
    checkOutput("abort_data_untouched", out_data, 32'd4);
    applyStimulus(5'd0, 32'd0, 1'b0, 1'b0, 2'b00, 2'b01, 5'd0, 5'd5, 32'd0, 0);
    checkOutput("reset_data5", out_data, 32'd5);

    $display("[TB] randomized transactions");
    for (int run = 0; run < 3; run++) begin
      doReset();
      for (int n = 0; n < 40 && !m_halt; n++) begin
        r_wb  = 5'($urandom_range(0, 31));
        r_res = $urandom;
        r_br  = ($urandom_range(0, 7) == 0);
        r_jal = ($urandom_range(0, 7) == 0);
        r_lwr = 2'($urandom_range(0, 3));
        r_io  = 2'($urandom_range(0, 3));
        r_la  = 5'($urandom_range(0, 31));
        r_ia  = 5'($urandom_range(0, 31));
        r_ind = $urandom;
        applyStimulus(r_wb, r_res, r_br, r_jal, r_lwr, r_io, r_la, r_ia, r_ind, $urandom_range(0, 3));
        checkRegs("rand_regs");
      end
      checkOutput("rand_halted", 32'(halted), 32'(m_halt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
